// File: rtl/ram_req_bridge.sv
`default_nettype none
// ============================================================================
// Module      : ram_req_bridge
// Description : In-order request bridge in front of the DPI RAM model. Queues
//               client read/write requests, issues them on the RAM model's
//               valid/ready request pins under outstanding-credit limits, and
//               collects read data into a response FIFO and write completions
//               into a one-cycle done pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module ram_req_bridge #(
    parameter int REQ_DEPTH  = 4,
    parameter int MAX_RD_OUT = 4,
    parameter int MAX_WR_OUT = 4,
    parameter int RAW_FENCE  = 1
) (
    input  logic                               clk,
    input  logic                               rst_n,
    // client request side
    input  logic                               req_valid,
    output logic                               req_ready,
    input  logic                               req_we,
    input  logic [63:0]                        req_addr,
    input  logic [63:0]                        req_wdata,
    // client response side
    output logic                               rd_rsp_valid,
    input  logic                               rd_rsp_ready,
    output logic [63:0]                        rd_rsp_data,
    output logic                               wr_done,
    // RAM model request side
    output logic                               rvalid,
    output logic [63:0]                        raddr,
    output logic                               wvalid,
    output logic [63:0]                        waddr,
    output logic [63:0]                        wdata,
    input  logic                               readReady,
    input  logic                               writeReady,
    // RAM model completion side
    input  logic                               readfin,
    input  logic                               writefin,
    input  logic [63:0]                        rdata,
    // status
    output logic [$clog2(MAX_RD_OUT+1)-1:0]    rd_outstanding,
    output logic [$clog2(MAX_WR_OUT+1)-1:0]    wr_outstanding,
    output logic                               idle,
    output logic                               err
);

    localparam int QAW = $clog2(REQ_DEPTH);
    localparam int RDW = $clog2(MAX_RD_OUT + 1);
    localparam int WRW = $clog2(MAX_WR_OUT + 1);
    localparam int RIW = (MAX_RD_OUT > 1) ? $clog2(MAX_RD_OUT) : 1;
    localparam int RCW = RIW + 1;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [QAW:0]   req_wptr_q, req_wptr_d;
    logic [QAW:0]   req_rptr_q, req_rptr_d;
    logic           req_we_mem_q   [REQ_DEPTH];
    logic           req_we_mem_d   [REQ_DEPTH];
    logic [63:0]    req_addr_mem_q [REQ_DEPTH];
    logic [63:0]    req_addr_mem_d [REQ_DEPTH];
    logic [63:0]    req_data_mem_q [REQ_DEPTH];
    logic [63:0]    req_data_mem_d [REQ_DEPTH];

    logic [RIW:0]   rsp_wptr_q, rsp_wptr_d;
    logic [RIW:0]   rsp_rptr_q, rsp_rptr_d;
    logic [63:0]    rsp_mem_q [MAX_RD_OUT];
    logic [63:0]    rsp_mem_d [MAX_RD_OUT];

    logic [RDW-1:0] rd_out_q, rd_out_d;
    logic [WRW-1:0] wr_out_q, wr_out_d;
    logic           wr_done_q, wr_done_d;
    logic           err_q, err_d;

    // ------------------------------------------------------------------
    // Derived (state-only) decode
    // ------------------------------------------------------------------
    logic [QAW-1:0] head_idx;
    logic           req_empty;
    logic           req_full;
    logic           head_we;
    logic           rsp_empty;
    logic [RCW-1:0] rsp_count;
    logic           rd_credit_ok;
    logic           wr_credit_ok;
    logic           fence_ok;
    logic           rd_sel;
    logic           wr_sel;

    // Response pointers carry a wrap bit so non power-of-two depths still work.
    function automatic logic [RIW:0] rsp_ptr_inc(input logic [RIW:0] p);
        if (p[RIW-1:0] == RIW'(MAX_RD_OUT - 1)) begin
            return {~p[RIW], {RIW{1'b0}}};
        end
        return {p[RIW], p[RIW-1:0] + RIW'(1)};
    endfunction

    assign head_idx  = req_rptr_q[QAW-1:0];
    assign req_empty = (req_wptr_q == req_rptr_q);
    assign req_full  = (req_wptr_q[QAW] != req_rptr_q[QAW]) &&
                       (req_wptr_q[QAW-1:0] == req_rptr_q[QAW-1:0]);
    assign head_we   = req_we_mem_q[head_idx];
    assign rsp_empty = (rsp_wptr_q == rsp_rptr_q);

    // Response occupancy from the wrap-bit pointer pair.
    always_comb begin
        rsp_count = '0;
        if (rsp_wptr_q[RIW] == rsp_rptr_q[RIW]) begin
            rsp_count = {1'b0, rsp_wptr_q[RIW-1:0]} - {1'b0, rsp_rptr_q[RIW-1:0]};
        end else begin
            rsp_count = RCW'(MAX_RD_OUT) - {1'b0, rsp_rptr_q[RIW-1:0]}
                      + {1'b0, rsp_wptr_q[RIW-1:0]};
        end
    end

    // Read credit covers both in-flight reads and data parked in the response
    // FIFO, which is what keeps the non-backpressurable readfin from overflowing.
    assign rd_credit_ok = (32'(rd_out_q) + 32'(rsp_count)) < 32'(MAX_RD_OUT);
    assign wr_credit_ok = 32'(wr_out_q) < 32'(MAX_WR_OUT);
    assign fence_ok     = (RAW_FENCE == 0) || (wr_out_q == '0);

    assign rd_sel = !req_empty && !head_we && rd_credit_ok && fence_ok;
    assign wr_sel = !req_empty &&  head_we && wr_credit_ok;

    // Request-side outputs decode registered state only; addresses are zeroed
    // when not valid so stale FIFO contents never appear on the pins.
    assign rvalid    = rd_sel;
    assign raddr     = rd_sel ? req_addr_mem_q[head_idx] : 64'd0;
    assign wvalid    = wr_sel;
    assign waddr     = wr_sel ? req_addr_mem_q[head_idx] : 64'd0;
    assign wdata     = wr_sel ? req_data_mem_q[head_idx] : 64'd0;
    assign req_ready = !req_full;

    assign rd_rsp_valid   = !rsp_empty;
    assign rd_rsp_data    = rsp_empty ? 64'd0 : rsp_mem_q[rsp_rptr_q[RIW-1:0]];
    assign wr_done        = wr_done_q;
    assign rd_outstanding = rd_out_q;
    assign wr_outstanding = wr_out_q;
    assign err            = err_q;
    assign idle           = req_empty && rsp_empty && (rd_out_q == '0) && (wr_out_q == '0);

    // ------------------------------------------------------------------
    // Events
    // ------------------------------------------------------------------
    logic req_push;
    logic issue_rd;
    logic issue_wr;
    logic rd_fin_ok;
    logic wr_fin_ok;
    logic rsp_pop;

    assign req_push  = req_valid && !req_full;
    assign issue_rd  = rd_sel && readReady;
    assign issue_wr  = wr_sel && writeReady;
    assign rd_fin_ok = readfin  && (rd_out_q != '0);
    assign wr_fin_ok = writefin && (wr_out_q != '0);
    assign rsp_pop   = rd_rsp_ready && !rsp_empty;

    // Request FIFO next state: push at the tail, pop the head on issue.
    always_comb begin
        req_wptr_d     = req_wptr_q;
        req_rptr_d     = req_rptr_q;
        req_we_mem_d   = req_we_mem_q;
        req_addr_mem_d = req_addr_mem_q;
        req_data_mem_d = req_data_mem_q;
        if (req_push) begin
            req_we_mem_d[req_wptr_q[QAW-1:0]]   = req_we;
            req_addr_mem_d[req_wptr_q[QAW-1:0]] = req_addr;
            req_data_mem_d[req_wptr_q[QAW-1:0]] = req_wdata;
            req_wptr_d = req_wptr_q + (QAW+1)'(1);
        end
        if (issue_rd || issue_wr) begin
            req_rptr_d = req_rptr_q + (QAW+1)'(1);
        end
    end

    // Response FIFO next state: accepted readfin pushes, client ready pops.
    always_comb begin
        rsp_wptr_d = rsp_wptr_q;
        rsp_rptr_d = rsp_rptr_q;
        rsp_mem_d  = rsp_mem_q;
        if (rd_fin_ok) begin
            rsp_mem_d[rsp_wptr_q[RIW-1:0]] = rdata;
            rsp_wptr_d = rsp_ptr_inc(rsp_wptr_q);
        end
        if (rsp_pop) begin
            rsp_rptr_d = rsp_ptr_inc(rsp_rptr_q);
        end
    end

    // Outstanding counters, write-done pulse and sticky error.
    always_comb begin
        rd_out_d  = rd_out_q;
        wr_out_d  = wr_out_q;
        wr_done_d = wr_fin_ok;
        err_d     = err_q || (readfin && (rd_out_q == '0)) || (writefin && (wr_out_q == '0));
        case ({issue_rd, rd_fin_ok})
            2'b10:   rd_out_d = rd_out_q + RDW'(1);
            2'b01:   rd_out_d = rd_out_q - RDW'(1);
            default: rd_out_d = rd_out_q;
        endcase
        case ({issue_wr, wr_fin_ok})
            2'b10:   wr_out_d = wr_out_q + WRW'(1);
            2'b01:   wr_out_d = wr_out_q - WRW'(1);
            default: wr_out_d = wr_out_q;
        endcase
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_wptr_q <= '0;
            req_rptr_q <= '0;
            for (int i = 0; i < REQ_DEPTH; i++) begin
                req_we_mem_q[i]   <= 1'b0;
                req_addr_mem_q[i] <= 64'd0;
                req_data_mem_q[i] <= 64'd0;
            end
            rsp_wptr_q <= '0;
            rsp_rptr_q <= '0;
            for (int i = 0; i < MAX_RD_OUT; i++) begin
                rsp_mem_q[i] <= 64'd0;
            end
            rd_out_q  <= '0;
            wr_out_q  <= '0;
            wr_done_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            req_wptr_q     <= req_wptr_d;
            req_rptr_q     <= req_rptr_d;
            req_we_mem_q   <= req_we_mem_d;
            req_addr_mem_q <= req_addr_mem_d;
            req_data_mem_q <= req_data_mem_d;
            rsp_wptr_q     <= rsp_wptr_d;
            rsp_rptr_q     <= rsp_rptr_d;
            rsp_mem_q      <= rsp_mem_d;
            rd_out_q       <= rd_out_d;
            wr_out_q       <= wr_out_d;
            wr_done_q      <= wr_done_d;
            err_q          <= err_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ram_req_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_ram_req_bridge
// Description : Directed self-checking bench for ram_req_bridge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_req_bridge;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [63:0] req_addr = '0;
    logic [63:0] req_wdata = '0;
    logic        rd_rsp_valid;
    logic        rd_rsp_ready = 1'b0;
    logic [63:0] rd_rsp_data;
    logic        wr_done;
    logic        rvalid;
    logic [63:0] raddr;
    logic        wvalid;
    logic [63:0] waddr;
    logic [63:0] wdata;
    logic        readReady = 1'b0;
    logic        writeReady = 1'b0;
    logic        readfin = 1'b0;
    logic        writefin = 1'b0;
    logic [63:0] rdata = '0;
    logic [2:0]  rd_outstanding;
    logic [2:0]  wr_outstanding;
    logic        idle;
    logic        err;

    int n_cmp  = 0;
    int n_fail = 0;

    ram_req_bridge #(
        .REQ_DEPTH (4),
        .MAX_RD_OUT(4),
        .MAX_WR_OUT(4),
        .RAW_FENCE (1)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_we        (req_we),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .rd_rsp_valid  (rd_rsp_valid),
        .rd_rsp_ready  (rd_rsp_ready),
        .rd_rsp_data   (rd_rsp_data),
        .wr_done       (wr_done),
        .rvalid        (rvalid),
        .raddr         (raddr),
        .wvalid        (wvalid),
        .waddr         (waddr),
        .wdata         (wdata),
        .readReady     (readReady),
        .writeReady    (writeReady),
        .readfin       (readfin),
        .writefin      (writefin),
        .rdata         (rdata),
        .rd_outstanding(rd_outstanding),
        .wr_outstanding(wr_outstanding),
        .idle          (idle),
        .err           (err)
    );

    always #5 clk = ~clk;

    // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Push one request (one accepting edge).
    task automatic push(input logic we, input logic [63:0] a, input logic [63:0] d);
        req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
        tick();
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        n_cmp++; if (rvalid !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid got %b want 0", rvalid); end
        n_cmp++; if (wvalid !== 1'b0) begin n_fail++; $display("FAIL reset_wvalid got %b want 0", wvalid); end
        n_cmp++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready got %b want 1", req_ready); end
        n_cmp++; if (idle !== 1'b1) begin n_fail++; $display("FAIL reset_idle got %b want 1", idle); end
        n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b want 0", err); end
        n_cmp++; if (rd_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid got %b want 0", rd_rsp_valid); end
        n_cmp++; if (rd_rsp_data !== 64'd0) begin n_fail++; $display("FAIL reset_rsp_data got %h want 0", rd_rsp_data); end
        n_cmp++; if (rd_outstanding !== 3'd0 || wr_outstanding !== 3'd0) begin n_fail++; $display("FAIL reset_counts got %0d/%0d want 0/0", rd_outstanding, wr_outstanding); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single_read();
        readReady = 1'b1;
        push(1'b0, 64'h100, 64'd0);
        n_cmp++; if (rvalid !== 1'b1 || raddr !== 64'h100) begin n_fail++; $display("FAIL single_present got rvalid=%b raddr=%h want 1/100", rvalid, raddr); end
        tick();
        n_cmp++; if (rd_outstanding !== 3'd1 || rvalid !== 1'b0) begin n_fail++; $display("FAIL single_issue got out=%0d rvalid=%b want 1/0", rd_outstanding, rvalid); end
        n_cmp++; if (idle !== 1'b0) begin n_fail++; $display("FAIL single_busy got idle=%b want 0", idle); end
        repeat (4) tick();
        readfin = 1'b1; rdata = 64'hDEADBEEF;
        tick();
        readfin = 1'b0; rdata = '0;
        n_cmp++; if (rd_rsp_valid !== 1'b1 || rd_rsp_data !== 64'hDEADBEEF) begin n_fail++; $display("FAIL single_rsp got v=%b d=%h want 1/deadbeef", rd_rsp_valid, rd_rsp_data); end
        n_cmp++; if (rd_outstanding !== 3'd0) begin n_fail++; $display("FAIL single_out_dec got %0d want 0", rd_outstanding); end
        rd_rsp_ready = 1'b1;
        tick();
        rd_rsp_ready = 1'b0;
        n_cmp++; if (rd_rsp_valid !== 1'b0 || idle !== 1'b1) begin n_fail++; $display("FAIL single_pop got v=%b idle=%b want 0/1", rd_rsp_valid, idle); end
        readReady = 1'b0;
    endtask

    task automatic test_credit_limit();
        readReady = 1'b1;
        rd_rsp_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            req_valid = 1'b1; req_we = 1'b0; req_addr = 64'h200 + 64'(i * 8);
            tick();
        end
        req_valid = 1'b0; req_addr = '0;
        repeat (2) tick();
        n_cmp++; if (rd_outstanding !== 3'd4) begin n_fail++; $display("FAIL credit_out got %0d want 4", rd_outstanding); end
        n_cmp++; if (rvalid !== 1'b0) begin n_fail++; $display("FAIL credit_hold got rvalid=%b want 0", rvalid); end
        readReady = 1'b0;
        for (int i = 0; i < 4; i++) begin
            readfin = 1'b1; rdata = 64'hA0 + 64'(i);
            tick();
        end
        readfin = 1'b0; rdata = '0;
        n_cmp++; if (rd_outstanding !== 3'd0 || rvalid !== 1'b0) begin n_fail++; $display("FAIL credit_full_rsp got out=%0d rvalid=%b want 0/0", rd_outstanding, rvalid); end
        n_cmp++; if (rd_rsp_data !== 64'hA0) begin n_fail++; $display("FAIL credit_rsp0 got %h want a0", rd_rsp_data); end
        rd_rsp_ready = 1'b1;
        tick();
        rd_rsp_ready = 1'b0;
        n_cmp++; if (rvalid !== 1'b1 || raddr !== 64'h220) begin n_fail++; $display("FAIL credit_fifth got rvalid=%b raddr=%h want 1/220", rvalid, raddr); end
        for (int i = 1; i < 4; i++) begin
            n_cmp++; if (rd_rsp_data !== 64'hA0 + 64'(i)) begin n_fail++; $display("FAIL credit_rsp_order got %h want %h", rd_rsp_data, 64'hA0 + 64'(i)); end
            rd_rsp_ready = 1'b1;
            tick();
            rd_rsp_ready = 1'b0;
        end
        n_cmp++; if (rd_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL credit_drained got %b want 0", rd_rsp_valid); end
        readReady = 1'b1;
        repeat (2) tick();
        readReady = 1'b0;
        n_cmp++; if (rd_outstanding !== 3'd2) begin n_fail++; $display("FAIL credit_tail_issue got %0d want 2", rd_outstanding); end
        readfin = 1'b1; rd_rsp_ready = 1'b1;
        repeat (2) tick();
        readfin = 1'b0;
        tick();
        rd_rsp_ready = 1'b0;
        n_cmp++; if (idle !== 1'b1) begin n_fail++; $display("FAIL credit_idle got %b want 1", idle); end
    endtask

    task automatic test_raw_fence();
        writeReady = 1'b1; readReady = 1'b1;
        req_valid = 1'b1; req_we = 1'b1; req_addr = 64'h40; req_wdata = 64'h1234;
        tick();
        n_cmp++; if (wvalid !== 1'b1 || waddr !== 64'h40 || wdata !== 64'h1234) begin n_fail++; $display("FAIL fence_wpresent got v=%b a=%h d=%h want 1/40/1234", wvalid, waddr, wdata); end
        req_we = 1'b0; req_wdata = '0;
        tick();
        req_valid = 1'b0; req_addr = '0;
        n_cmp++; if (wr_outstanding !== 3'd1 || rvalid !== 1'b0) begin n_fail++; $display("FAIL fence_block got wout=%0d rvalid=%b want 1/0", wr_outstanding, rvalid); end
        repeat (2) begin
            tick();
            n_cmp++; if (rvalid !== 1'b0) begin n_fail++; $display("FAIL fence_wait got rvalid=%b want 0", rvalid); end
        end
        writefin = 1'b1;
        tick();
        writefin = 1'b0;
        n_cmp++; if (wr_done !== 1'b1 || wr_outstanding !== 3'd0) begin n_fail++; $display("FAIL fence_wrdone got done=%b wout=%0d want 1/0", wr_done, wr_outstanding); end
        n_cmp++; if (rvalid !== 1'b1 || raddr !== 64'h40) begin n_fail++; $display("FAIL fence_release got rvalid=%b raddr=%h want 1/40", rvalid, raddr); end
        tick();
        n_cmp++; if (wr_done !== 1'b0 || rd_outstanding !== 3'd1) begin n_fail++; $display("FAIL fence_pulse got done=%b rout=%0d want 0/1", wr_done, rd_outstanding); end
        writeReady = 1'b0; readReady = 1'b0;
        readfin = 1'b1; rdata = 64'h55;
        tick();
        readfin = 1'b0; rdata = '0; rd_rsp_ready = 1'b1;
        tick();
        rd_rsp_ready = 1'b0;
        n_cmp++; if (idle !== 1'b1) begin n_fail++; $display("FAIL fence_idle got %b want 1", idle); end
    endtask

    task automatic test_backpressure();
        logic stable_ok;
        readReady = 1'b0;
        stable_ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            req_valid = (i < 4); req_we = 1'b0; req_addr = 64'h300 + 64'(i * 8);
            tick();
            if (rvalid !== 1'b1 || raddr !== 64'h300) stable_ok = 1'b0;
            if (i == 3) begin
                n_cmp++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL bp_full got req_ready=%b want 0", req_ready); end
            end
        end
        req_valid = 1'b0; req_addr = '0;
        n_cmp++; if (stable_ok !== 1'b1) begin n_fail++; $display("FAIL bp_stable got %b want 1", stable_ok); end
        readReady = 1'b1;
        repeat (4) tick();
        readReady = 1'b0;
        n_cmp++; if (req_ready !== 1'b1 || rd_outstanding !== 3'd4) begin n_fail++; $display("FAIL bp_drain got ready=%b out=%0d want 1/4", req_ready, rd_outstanding); end
        readfin = 1'b1; rd_rsp_ready = 1'b1;
        repeat (4) tick();
        readfin = 1'b0;
        tick();
        rd_rsp_ready = 1'b0;
        n_cmp++; if (idle !== 1'b1) begin n_fail++; $display("FAIL bp_idle got %b want 1", idle); end
    endtask

    task automatic test_simultaneous();
        readReady = 1'b1; rd_rsp_ready = 1'b0;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 64'h500;
        tick();
        req_addr = 64'h508;
        tick();
        req_valid = 1'b0; req_addr = '0;
        n_cmp++; if (rd_outstanding !== 3'd1 || rvalid !== 1'b1) begin n_fail++; $display("FAIL sim_setup got out=%0d rvalid=%b want 1/1", rd_outstanding, rvalid); end
        readfin = 1'b1; rdata = 64'h111;
        tick();
        n_cmp++; if (rd_outstanding !== 3'd1) begin n_fail++; $display("FAIL sim_issue_fin got %0d want 1", rd_outstanding); end
        n_cmp++; if (rd_rsp_valid !== 1'b1 || rd_rsp_data !== 64'h111) begin n_fail++; $display("FAIL sim_rsp1 got v=%b d=%h want 1/111", rd_rsp_valid, rd_rsp_data); end
        rdata = 64'h222; rd_rsp_ready = 1'b1;
        tick();
        readfin = 1'b0; rdata = '0;
        n_cmp++; if (rd_rsp_valid !== 1'b1 || rd_rsp_data !== 64'h222 || rd_outstanding !== 3'd0) begin n_fail++; $display("FAIL sim_push_pop got v=%b d=%h out=%0d want 1/222/0", rd_rsp_valid, rd_rsp_data, rd_outstanding); end
        tick();
        rd_rsp_ready = 1'b0; readReady = 1'b0;
        n_cmp++; if (idle !== 1'b1) begin n_fail++; $display("FAIL sim_idle got %b want 1", idle); end
    endtask

    task automatic test_err_reset();
        writefin = 1'b1;
        tick();
        writefin = 1'b0;
        n_cmp++; if (err !== 1'b1 || wr_done !== 1'b0 || wr_outstanding !== 3'd0) begin n_fail++; $display("FAIL err_wfin got err=%b done=%b wout=%0d want 1/0/0", err, wr_done, wr_outstanding); end
        repeat (3) tick();
        n_cmp++; if (err !== 1'b1) begin n_fail++; $display("FAIL err_sticky got %b want 1", err); end
        readfin = 1'b1;
        tick();
        readfin = 1'b0;
        n_cmp++; if (rd_outstanding !== 3'd0 || rd_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL err_rfin_drop got out=%0d v=%b want 0/0", rd_outstanding, rd_rsp_valid); end
        writeReady = 1'b1; readReady = 1'b0;
        push(1'b1, 64'h600, 64'h77);
        push(1'b0, 64'h608, 64'd0);
        push(1'b0, 64'h610, 64'd0);
        n_cmp++; if (wr_outstanding !== 3'd1 || idle !== 1'b0) begin n_fail++; $display("FAIL err_burst got wout=%0d idle=%b want 1/0", wr_outstanding, idle); end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (err !== 1'b0 || wr_outstanding !== 3'd0 || rd_outstanding !== 3'd0) begin n_fail++; $display("FAIL async_rst_state got err=%b wout=%0d rout=%0d want 0/0/0", err, wr_outstanding, rd_outstanding); end
        n_cmp++; if (rvalid !== 1'b0 || wvalid !== 1'b0 || waddr !== 64'd0 || wdata !== 64'd0 || raddr !== 64'd0) begin n_fail++; $display("FAIL async_rst_req got rv=%b wv=%b ra=%h wa=%h wd=%h want all 0", rvalid, wvalid, raddr, waddr, wdata); end
        n_cmp++; if (req_ready !== 1'b1 || idle !== 1'b1 || wr_done !== 1'b0 || rd_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL async_rst_misc got ready=%b idle=%b done=%b v=%b want 1/1/0/0", req_ready, idle, wr_done, rd_rsp_valid); end
        writeReady = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        n_cmp++; if (idle !== 1'b1 || err !== 1'b0) begin n_fail++; $display("FAIL post_rst got idle=%b err=%b want 1/0", idle, err); end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_credit_limit();
        test_raw_fence();
        test_backpressure();
        test_simultaneous();
        test_err_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ram_req_bridge.md
# ram_req_bridge

Request-side bridge that sits directly upstream of the DPI RAM model and is the only block driving its read/write request pins. It accepts a single in-order stream of 64-bit read/write requests from a client, queues them, and issues them onto the RAM model's valid/ready request interface under outstanding-transaction credit limits. It also collects the RAM model's non-backpressurable completion pulses: read data goes into a response FIFO, and writes produce a done pulse.

## Interface
- REQ_DEPTH, 4 — request FIFO entries; power of two, ≥2.
- MAX_RD_OUT, 4 — limit on reads in flight plus reads held in the response FIFO; the response FIFO has MAX_RD_OUT entries.
- MAX_WR_OUT, 4 — maximum writes issued but not yet finished.
- RAW_FENCE, 1 — when 1, a read at the FIFO head is not issued while wr_outstanding != 0.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  1  client request valid.
- req_ready  out  1  request FIFO not full.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  64  request address.
- req_wdata  in  64  write data; ignored for reads.
- rd_rsp_valid  out  1  response FIFO not empty.
- rd_rsp_ready  in  1  client pops a response.
- rd_rsp_data  out  64  read data at the response FIFO head.
- wr_done  out  1  one-cycle pulse per completed write.
- rvalid  out  1  read request to the RAM model.
- raddr  out  64  read address.
- wvalid  out  1  write request to the RAM model.
- waddr  out  64  write address.
- wdata  out  64  write data.
- readReady  in  1  RAM model can accept a read.
- writeReady  in  1  RAM model can accept a write.
- readfin  in  1  read completion pulse; rdata is valid in the same cycle.
- writefin  in  1  write completion pulse.
- rdata  in  64  completed read data.
- rd_outstanding  out  clog2(MAX_RD_OUT+1)  reads issued but not yet finished.
- wr_outstanding  out  clog2(MAX_WR_OUT+1)  writes issued but not yet finished.
- idle  out  1  both FIFOs empty and both outstanding counters 0.
- err  out  1  sticky protocol error flag.

## Operation
- Client-side acceptance: a request is pushed into the request FIFO on a posedge where req_valid && req_ready.
- Dispatch is strictly in order from the FIFO head. At most one of rvalid/wvalid is high in any cycle. No request is reordered past another.
- Read at head: rvalid=1 and raddr=head address when both hold:
  - rd_outstanding + rsp_count < MAX_RD_OUT;
  - if RAW_FENCE=1, wr_outstanding == 0.
- Write at head: wvalid=1, waddr=head address, wdata=head data when wr_outstanding < MAX_WR_OUT.
- Issue handshake: a request is issued on a posedge where rvalid && readReady (or wvalid && writeReady). That edge pops the head and increments the matching outstanding counter.
- Until issued, valid and address/data stay stable. Valid never drops without a handshake.
- Read completion: on readfin, rdata is pushed into the response FIFO and rd_outstanding decrements. The credit rule guarantees the response FIFO never overflows.
- Write completion: on writefin, wr_done pulses in the next cycle and wr_outstanding decrements.
- Same-edge issue and completion of one type: the counter is unchanged.
- Same-edge response FIFO push and pop: the count is unchanged and data order is preserved. This includes the full and empty cases.
- Error handling, all sticky until reset:
  - readfin with rd_outstanding == 0 sets err, and the completion is dropped.
  - writefin with wr_outstanding == 0 sets err, and the completion is dropped.
- FIFO pointers wrap modulo depth. Full and empty are distinguished by an extra pointer bit.
- Reset (async, any time, including mid-transaction) clears:
  - both FIFOs, both counters, and err;
  - the outputs to: rvalid=0, wvalid=0, raddr/waddr/wdata=0, rd_rsp_valid=0, rd_rsp_data=0, wr_done=0, err=0.
  - req_ready=1 and idle=1 after reset.
  - Completions for transactions issued before reset are not tracked.

## Timing
- rvalid, wvalid, raddr, waddr, wdata, req_ready and rd_rsp_valid decode registered state only. There is no combinational path from readReady/writeReady/readfin/writefin/rd_rsp_ready to any output.
- A request pushed at edge N is visible on rvalid/wvalid from cycle N+1, when at head and credits allow. The next head is presented one cycle after the issue edge. Sustained throughput is 1 issue per cycle.
- readfin sampled at edge M gives rd_rsp_valid=1 with that data from cycle M+1.
- writefin sampled at edge M gives wr_done=1 for exactly cycle M+1.
- Counters and idle update on the same edge as the event that changes them.

## Test plan
- Single read: request read 0x100; readReady=1; readfin 5 cycles later with rdata=0xDEADBEEF.
  - rvalid at N+1, raddr=0x100; rd_rsp_data=0xDEADBEEF one cycle after readfin; idle returns to 1 after rd_rsp_ready pops it.
- Read credit limit: 6 back-to-back reads, no readfin, rd_rsp_ready=0.
  - Exactly 4 issued, rd_outstanding=4, rvalid held low.
  - 4 readfins then produce 4 responses in order; the 5th read issues only after the first pop.
- RAW fence: write 0x40 then read 0x40, with writefin 3 cycles after issue.
  - rvalid stays 0 until the cycle after writefin; wr_done pulses for one cycle.
- Backpressure: readReady=0 for 10 cycles with a read at head.
  - rvalid=1 and raddr stable throughout; the FIFO fills and req_ready=0 after 4 pushes.
- Simultaneous events: readfin on the same edge as a new read issue keeps rd_outstanding unchanged. Response push and pop on the same edge with one entry keeps rd_rsp_valid=1 with the new data.
- Errors and reset: a spurious writefin at idle sets err=1, which stays 1. rst_n low mid-burst clears err and all counters, with all outputs at reset values immediately.
